// File: rtl/alu_pwr_pkg.sv
// rtl/alu_pwr_pkg.sv - shared constants and state encoding for the ALU power sequencer
package alu_pwr_pkg;

    localparam int ALU_DW  = 16;
    localparam int ALU_OPW = 4;

    typedef enum logic [1:0] {
        PS_OFF    = 2'd0,
        PS_PWR_UP = 2'd1,
        PS_ON     = 2'd2,
        PS_ISO_DN = 2'd3
    } pwr_state_e;

endpackage

// File: rtl/pwr_dly_cnt.sv
// rtl/pwr_dly_cnt.sv - loadable down-counter timing the power-up and isolation-setup windows
module pwr_dly_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // Load wins over counting; the counter parks at zero until the next load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Loading N-1 makes done true in the Nth cycle after the load
    assign done = (cnt == '0);

endmodule

// File: rtl/alu_pwr_ctrl.sv
// rtl/alu_pwr_ctrl.sv - power-sequencing front end for the power-gated ALU
module alu_pwr_ctrl
    import alu_pwr_pkg::*;
#(
    parameter int PWR_UP_DLY   = 4,
    parameter int ISO_SETUP    = 2,
    parameter int IDLE_TIMEOUT = 16,
    parameter int CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ALU_DW-1:0]  req_A,
    input  logic [ALU_DW-1:0]  req_B,
    input  logic [ALU_OPW-1:0] req_opcode,
    input  logic               sleep_req,
    input  logic               alu_busy,
    output logic               alu_start,
    output logic [ALU_DW-1:0]  alu_A,
    output logic [ALU_DW-1:0]  alu_B,
    output logic [ALU_OPW-1:0] alu_opcode,
    output logic               alu_pwr_en,
    output logic               iso_en,
    output logic [1:0]         pwr_state
);

    pwr_state_e       state_q;
    pwr_state_e       state_d;
    logic             dly_load;
    logic [CNT_W-1:0] dly_value;
    logic             dly_done;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] idle_cnt_d;
    logic             idle_now;
    logic             idle_expired;
    logic             accept;

    pwr_dly_cnt #(
        .CNT_W (CNT_W)
    ) u_dly_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (dly_load),
        .value (dly_value),
        .done  (dly_done)
    );

    // Sleep takes priority over a new request, so a request is never accepted while sleep_req is up
    assign req_ready = (state_q == PS_ON) & ~alu_busy & ~alu_start & ~sleep_req;
    assign accept    = req_valid & req_ready;
    assign idle_now  = ~req_valid & ~alu_busy & ~alu_start;
    assign pwr_state = state_q;

    // Saturating count of consecutive idle cycles, including the current one
    always_comb begin
        idle_cnt_d = '0;
        if (state_q == PS_ON && idle_now) begin
            idle_cnt_d = (idle_cnt == {CNT_W{1'b1}}) ? idle_cnt : idle_cnt + CNT_W'(1);
        end
    end

    assign idle_expired = (IDLE_TIMEOUT != 0) && (idle_cnt_d >= CNT_W'(IDLE_TIMEOUT));

    // Next-state logic and delay-counter loads on entry to the timed states
    always_comb begin
        state_d   = state_q;
        dly_load  = 1'b0;
        dly_value = '0;
        case (state_q)
            PS_OFF: begin
                if (req_valid && !sleep_req) begin
                    state_d   = PS_PWR_UP;
                    dly_load  = 1'b1;
                    dly_value = CNT_W'(PWR_UP_DLY - 1);
                end
            end
            PS_PWR_UP: begin
                if (dly_done) begin
                    state_d = PS_ON;
                end
            end
            PS_ON: begin
                if ((sleep_req || idle_expired) && !alu_busy && !alu_start) begin
                    state_d   = PS_ISO_DN;
                    dly_load  = 1'b1;
                    dly_value = CNT_W'(ISO_SETUP - 1);
                end
            end
            PS_ISO_DN: begin
                if (dly_done) begin
                    state_d = PS_OFF;
                end
            end
            default: state_d = PS_OFF;
        endcase
    end

    // State register; power and isolation are decoded from the next state so they change with it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= PS_OFF;
            alu_pwr_en <= 1'b0;
            iso_en     <= 1'b1;
        end else begin
            state_q    <= state_d;
            alu_pwr_en <= (state_d != PS_OFF);
            iso_en     <= (state_d != PS_ON);
        end
    end

    // Request register: operands hold from the start pulse until the next accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_start  <= 1'b0;
            alu_A      <= '0;
            alu_B      <= '0;
            alu_opcode <= '0;
        end else begin
            alu_start <= accept;
            if (accept) begin
                alu_A      <= req_A;
                alu_B      <= req_B;
                alu_opcode <= req_opcode;
            end
        end
    end

    // Idle counter is cleared whenever the FSM is not staying in ON
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= (state_d == PS_ON) ? idle_cnt_d : '0;
        end
    end

endmodule

// File: tb/tb_alu_pwr_ctrl.sv
// tb/tb_alu_pwr_ctrl.sv - directed self-checking bench for alu_pwr_ctrl
module tb_alu_pwr_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_A;
    logic [15:0] req_B;
    logic [3:0]  req_opcode;
    logic        sleep_req;
    logic        alu_busy;
    logic        alu_start;
    logic [15:0] alu_A;
    logic [15:0] alu_B;
    logic [3:0]  alu_opcode;
    logic        alu_pwr_en;
    logic        iso_en;
    logic [1:0]  pwr_state;

    int checks   = 0;
    int failures = 0;
    bit inv_en   = 1'b0;

    always #5 clk = ~clk;

    alu_pwr_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_A      (req_A),
        .req_B      (req_B),
        .req_opcode (req_opcode),
        .sleep_req  (sleep_req),
        .alu_busy   (alu_busy),
        .alu_start  (alu_start),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_opcode (alu_opcode),
        .alu_pwr_en (alu_pwr_en),
        .iso_en     (iso_en),
        .pwr_state  (pwr_state)
    );

    // Safety invariants watched on every cycle once the first reset has settled
    always @(negedge clk) begin
        if (inv_en) begin
            checks++;
            if (alu_pwr_en === 1'b0 && iso_en !== 1'b1) begin
                failures++;
                $display("FAIL inv_iso_when_off: iso_en=%b pwr_en=%b want iso_en=1 at %0t", iso_en, alu_pwr_en, $time);
            end
            checks++;
            if (alu_start === 1'b1 && pwr_state !== 2'd2) begin
                failures++;
                $display("FAIL inv_start_only_on: pwr_state=%0d want 2 while alu_start at %0t", pwr_state, $time);
            end
        end
    end

    task automatic do_wake(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        bit ok = 1'b0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_A      = a;
        req_B      = b;
        req_opcode = op;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (pwr_state === 2'd2) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wake_timeout: pwr_state=%0d want 2 within 12 cycles", pwr_state);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; req_A = '0; req_B = '0; req_opcode = '0;
        sleep_req = 1'b0; alu_busy = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (alu_pwr_en !== 1'b0) begin failures++; $display("FAIL reset_pwr_en: got %b want 0", alu_pwr_en); end
        checks++; if (iso_en !== 1'b1) begin failures++; $display("FAIL reset_iso_en: got %b want 1", iso_en); end
        checks++; if (pwr_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", pwr_state); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        checks++; if (alu_start !== 1'b0) begin failures++; $display("FAIL reset_start: got %b want 0", alu_start); end
        checks++; if (alu_A !== 16'h0 || alu_B !== 16'h0 || alu_opcode !== 4'h0) begin
            failures++; $display("FAIL reset_operands: got A=%h B=%h op=%h want 0", alu_A, alu_B, alu_opcode);
        end
        rst_n  = 1'b1;
        inv_en = 1'b1;
    endtask

    // Request in cycle t: pwr_en at t+1, ON/ready at t+5, start pulse at t+6
    task automatic test_wake;
        req_valid = 1'b1; req_A = 16'h0003; req_B = 16'h0005; req_opcode = 4'h0;
        @(negedge clk);
        checks++; if (alu_pwr_en !== 1'b1 || pwr_state !== 2'd1) begin
            failures++; $display("FAIL wake_t1: pwr_en=%b state=%0d want 1/1", alu_pwr_en, pwr_state);
        end
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            checks++; if (pwr_state !== 2'd1 || iso_en !== 1'b1) begin
                failures++; $display("FAIL wake_pwr_up_hold t+%0d: state=%0d iso=%b want 1/1", i, pwr_state, iso_en);
            end
        end
        @(negedge clk);
        #1;
        checks++; if (iso_en !== 1'b0 || pwr_state !== 2'd2) begin
            failures++; $display("FAIL wake_t5_on: iso=%b state=%0d want 0/2", iso_en, pwr_state);
        end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL wake_t5_ready: got %b want 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++; if (alu_start !== 1'b1 || alu_A !== 16'h0003 || alu_B !== 16'h0005) begin
            failures++; $display("FAIL wake_t6_start: start=%b A=%h B=%h want 1/0003/0005", alu_start, alu_A, alu_B);
        end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL wake_t6_ready: got %b want 0", req_ready); end
        @(negedge clk);
        checks++; if (alu_start !== 1'b0 || alu_A !== 16'h0003) begin
            failures++; $display("FAIL wake_t7_single_pulse: start=%b A=%h want 0/0003", alu_start, alu_A);
        end
    endtask

    // Continues from test_wake: the current cycle is the first idle cycle in ON
    task automatic test_idle_timeout;
        for (int i = 2; i <= 16; i++) begin
            @(negedge clk);
            checks++; if (pwr_state !== 2'd2 || iso_en !== 1'b0) begin
                failures++; $display("FAIL idle_still_on %0d: state=%0d iso=%b want 2/0", i, pwr_state, iso_en);
            end
        end
        @(negedge clk);
        checks++; if (iso_en !== 1'b1 || alu_pwr_en !== 1'b1 || pwr_state !== 2'd3) begin
            failures++; $display("FAIL idle_iso_dn: iso=%b pwr=%b state=%0d want 1/1/3", iso_en, alu_pwr_en, pwr_state);
        end
        repeat (2) @(negedge clk);
        checks++; if (alu_pwr_en !== 1'b0 || pwr_state !== 2'd0) begin
            failures++; $display("FAIL idle_off: pwr=%b state=%0d want 0/0", alu_pwr_en, pwr_state);
        end
    endtask

    task automatic test_sleep_busy;
        do_wake(16'h00aa, 16'h0055, 4'h1);
        @(negedge clk);
        req_valid = 1'b0; alu_busy = 1'b1; sleep_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checks++; if (pwr_state !== 2'd2 || iso_en !== 1'b0 || req_ready !== 1'b0) begin
                failures++; $display("FAIL sleep_busy_hold %0d: state=%0d iso=%b ready=%b want 2/0/0", i, pwr_state, iso_en, req_ready);
            end
        end
        alu_busy = 1'b0;
        @(negedge clk);
        checks++; if (iso_en !== 1'b1 || pwr_state !== 2'd3) begin
            failures++; $display("FAIL sleep_busy_release: iso=%b state=%0d want 1/3", iso_en, pwr_state);
        end
        repeat (2) @(negedge clk);
        checks++; if (alu_pwr_en !== 1'b0 || pwr_state !== 2'd0) begin
            failures++; $display("FAIL sleep_busy_off: pwr=%b state=%0d want 0/0", alu_pwr_en, pwr_state);
        end
    endtask

    task automatic test_sleep_vs_req;
        sleep_req = 1'b0;
        do_wake(16'h0102, 16'h0304, 4'h2);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        sleep_req = 1'b1; req_valid = 1'b1; req_A = 16'hdead;
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL sleep_vs_req_ready: got %b want 0", req_ready); end
        @(negedge clk);
        checks++; if (pwr_state !== 2'd3 || alu_start !== 1'b0) begin
            failures++; $display("FAIL sleep_vs_req_iso_dn: state=%0d start=%b want 3/0", pwr_state, alu_start);
        end
        @(negedge clk);
        checks++; if (pwr_state !== 2'd3) begin failures++; $display("FAIL sleep_vs_req_iso_hold: state=%0d want 3", pwr_state); end
        @(negedge clk);
        checks++; if (pwr_state !== 2'd0) begin failures++; $display("FAIL sleep_vs_req_off: state=%0d want 0", pwr_state); end
        @(negedge clk);
        checks++; if (pwr_state !== 2'd0 || alu_A !== 16'h0102) begin
            failures++; $display("FAIL sleep_vs_req_stay_off: state=%0d A=%h want 0/0102", pwr_state, alu_A);
        end
        sleep_req = 1'b0;
        @(negedge clk);
        checks++; if (pwr_state !== 2'd1 || alu_pwr_en !== 1'b1 || iso_en !== 1'b1) begin
            failures++; $display("FAIL sleep_vs_req_rewake: state=%0d pwr=%b iso=%b want 1/1/1", pwr_state, alu_pwr_en, iso_en);
        end
    endtask

    // Continues from test_sleep_vs_req: the current cycle is PWR_UP cycle 1
    task automatic test_reset_mid_pwr_up;
        @(negedge clk);
        checks++; if (pwr_state !== 2'd1) begin failures++; $display("FAIL mid_rst_pre: state=%0d want 1", pwr_state); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (alu_pwr_en !== 1'b0 || iso_en !== 1'b1 || pwr_state !== 2'd0) begin
            failures++; $display("FAIL mid_rst_off: pwr=%b iso=%b state=%0d want 0/1/0", alu_pwr_en, iso_en, pwr_state);
        end
        rst_n = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        checks++; if (pwr_state !== 2'd0) begin failures++; $display("FAIL mid_rst_stay_off: state=%0d want 0", pwr_state); end
    endtask

    task automatic test_back_to_back;
        do_wake(16'h1111, 16'h2222, 4'h3);
        @(negedge clk);
        req_A = 16'h3333; req_B = 16'h4444; req_opcode = 4'h5;
        #1;
        checks++; if (alu_start !== 1'b1 || alu_A !== 16'h1111 || alu_opcode !== 4'h3) begin
            failures++; $display("FAIL b2b_first: start=%b A=%h op=%h want 1/1111/3", alu_start, alu_A, alu_opcode);
        end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_during_start: got %b want 0", req_ready); end
        @(negedge clk);
        #1;
        checks++; if (alu_start !== 1'b0 || alu_A !== 16'h1111 || alu_B !== 16'h2222) begin
            failures++; $display("FAIL b2b_gap: start=%b A=%h B=%h want 0/1111/2222", alu_start, alu_A, alu_B);
        end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_after: got %b want 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (alu_start !== 1'b1 || alu_A !== 16'h3333 || alu_B !== 16'h4444 || alu_opcode !== 4'h5) begin
            failures++; $display("FAIL b2b_second: start=%b A=%h B=%h op=%h want 1/3333/4444/5", alu_start, alu_A, alu_B, alu_opcode);
        end
        @(negedge clk);
        checks++; if (alu_start !== 1'b0) begin failures++; $display("FAIL b2b_end: start=%b want 0", alu_start); end
    endtask

    initial begin
        test_reset;
        test_wake;
        test_idle_timeout;
        test_sleep_busy;
        test_sleep_vs_req;
        test_reset_mid_pwr_up;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
